// File: rtl/ram_writer.sv
// Captures one TLAST-terminated AXI-Stream frame into RAM as fixed-length INCR bursts.
// A trailing partial block is padded with WSTRB=0 beats so every burst has the same length.
module ram_writer #(
  parameter int unsigned DW               = 512,
  parameter int unsigned CYCLES_PER_BLOCK = 64,
  parameter logic [63:0] RAM_BASE_ADDR    = 64'h0,
  parameter logic [31:0] MAX_BLOCKS       = 32'h0010_0000
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  output logic            idle,
  output logic [31:0]     full_blocks,
  output logic [7:0]      partial_block_cycles,
  output logic            overflow,
  output logic            bresp_error,
  // Frame input stream
  input  logic [DW-1:0]   AXIS_IN_TDATA,
  input  logic            AXIS_IN_TVALID,
  input  logic            AXIS_IN_TLAST,
  output logic            AXIS_IN_TREADY,
  // Write address channel
  output logic [63:0]     M_AXI_AWADDR,
  output logic [7:0]      M_AXI_AWLEN,
  output logic [2:0]      M_AXI_AWSIZE,
  output logic [1:0]      M_AXI_AWBURST,
  output logic [3:0]      M_AXI_AWID,
  output logic [3:0]      M_AXI_AWCACHE,
  output logic [3:0]      M_AXI_AWQOS,
  output logic            M_AXI_AWLOCK,
  output logic [2:0]      M_AXI_AWPROT,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,
  // Write data channel
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WVALID,
  output logic            M_AXI_WLAST,
  input  logic            M_AXI_WREADY,
  // Write response channel
  input  logic [1:0]      M_AXI_BRESP,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY,
  // Read channels, unused by this writer
  output logic [63:0]     M_AXI_ARADDR,
  output logic [7:0]      M_AXI_ARLEN,
  output logic [2:0]      M_AXI_ARSIZE,
  output logic [1:0]      M_AXI_ARBURST,
  output logic [3:0]      M_AXI_ARID,
  output logic [3:0]      M_AXI_ARCACHE,
  output logic [3:0]      M_AXI_ARQOS,
  output logic            M_AXI_ARLOCK,
  output logic [2:0]      M_AXI_ARPROT,
  output logic            M_AXI_ARVALID,
  input  logic            M_AXI_ARREADY,
  input  logic [DW-1:0]   M_AXI_RDATA,
  input  logic [1:0]      M_AXI_RRESP,
  input  logic            M_AXI_RLAST,
  input  logic            M_AXI_RVALID,
  output logic            M_AXI_RREADY
);

  localparam logic [63:0] BLOCK_BYTES = 64'(CYCLES_PER_BLOCK) * 64'(DW / 8);
  localparam logic [7:0]  LAST_BEAT   = 8'(CYCLES_PER_BLOCK - 1);
  localparam logic [2:0]  AXSIZE      = 3'($clog2(DW / 8));

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAITD,
    S_AW,
    S_DATA,
    S_PAD,
    S_DROP,
    S_WAITB
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] full_blocks_q, full_blocks_d;
  logic [7:0]  partial_q, partial_d;
  logic        overflow_q, overflow_d;
  logic        bresp_err_q, bresp_err_d;
  logic [31:0] aw_cnt_q, aw_cnt_d;
  logic [31:0] b_cnt_q, b_cnt_d;
  logic [7:0]  beat_q, beat_d;
  logic        awvalid_q, awvalid_d;

  logic        beat_is_last;
  logic        data_hs;
  logic        unused_ok;

  assign beat_is_last = (beat_q == LAST_BEAT);
  assign data_hs      = (state_q == S_DATA) && AXIS_IN_TVALID && M_AXI_WREADY;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      full_blocks_q <= '0;
      partial_q     <= '0;
      overflow_q    <= 1'b0;
      bresp_err_q   <= 1'b0;
      aw_cnt_q      <= '0;
      b_cnt_q       <= '0;
      beat_q        <= '0;
      awvalid_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      full_blocks_q <= full_blocks_d;
      partial_q     <= partial_d;
      overflow_q    <= overflow_d;
      bresp_err_q   <= bresp_err_d;
      aw_cnt_q      <= aw_cnt_d;
      b_cnt_q       <= b_cnt_d;
      beat_q        <= beat_d;
      awvalid_q     <= awvalid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    full_blocks_d = full_blocks_q;
    partial_d     = partial_q;
    overflow_d    = overflow_q;
    bresp_err_d   = bresp_err_q;
    aw_cnt_d      = aw_cnt_q;
    b_cnt_d       = b_cnt_q;
    beat_d        = beat_q;
    awvalid_d     = awvalid_q;

    // Responses are counted whatever the state, so late B beats still drain WAITB
    if (M_AXI_BVALID) begin
      b_cnt_d = b_cnt_q + 32'd1;
      if (M_AXI_BRESP != 2'b00) begin
        bresp_err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          full_blocks_d = '0;
          partial_d     = '0;
          overflow_d    = 1'b0;
          bresp_err_d   = 1'b0;
          aw_cnt_d      = '0;
          b_cnt_d       = '0;
          state_d       = S_WAITD;
        end
      end
      S_WAITD: begin
        // An address is only issued once the block is known to carry data
        if (AXIS_IN_TVALID) begin
          if (full_blocks_q == MAX_BLOCKS) begin
            overflow_d = 1'b1;
            state_d    = S_DROP;
          end else begin
            awvalid_d = 1'b1;
            state_d   = S_AW;
          end
        end
      end
      S_AW: begin
        if (awvalid_q && M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
          aw_cnt_d  = aw_cnt_q + 32'd1;
          beat_d    = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (data_hs) begin
          if (beat_is_last) begin
            full_blocks_d = full_blocks_q + 32'd1;
            state_d       = AXIS_IN_TLAST ? S_WAITB : S_WAITD;
          end else if (AXIS_IN_TLAST) begin
            partial_d = beat_q + 8'd1;
            beat_d    = beat_q + 8'd1;
            state_d   = S_PAD;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      S_PAD: begin
        if (M_AXI_WREADY) begin
          if (beat_is_last) begin
            state_d = S_WAITB;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      S_DROP: begin
        overflow_d = 1'b1;
        if (AXIS_IN_TVALID && AXIS_IN_TLAST) begin
          state_d = S_WAITB;
        end
      end
      S_WAITB: begin
        if (b_cnt_q == aw_cnt_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign idle                 = (state_q == S_IDLE) && !start;
  assign full_blocks          = full_blocks_q;
  assign partial_block_cycles = partial_q;
  assign overflow             = overflow_q;
  assign bresp_error          = bresp_err_q;

  assign AXIS_IN_TREADY = ((state_q == S_DATA) && M_AXI_WREADY) || (state_q == S_DROP);

  // full_blocks is stable while an address is pending, so the address need not be registered
  assign M_AXI_AWADDR  = RAM_BASE_ADDR + ({32'd0, full_blocks_q} * BLOCK_BYTES);
  assign M_AXI_AWLEN   = LAST_BEAT;
  assign M_AXI_AWSIZE  = AXSIZE;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWID    = 4'd0;
  assign M_AXI_AWCACHE = 4'd0;
  assign M_AXI_AWQOS   = 4'd0;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_AWVALID = awvalid_q;

  assign M_AXI_WVALID = ((state_q == S_DATA) && AXIS_IN_TVALID) || (state_q == S_PAD);
  assign M_AXI_WDATA  = (state_q == S_DATA) ? AXIS_IN_TDATA : '0;
  assign M_AXI_WSTRB  = (state_q == S_DATA) ? '1 : '0;
  assign M_AXI_WLAST  = ((state_q == S_DATA) || (state_q == S_PAD)) && beat_is_last;

  assign M_AXI_BREADY = 1'b1;

  assign M_AXI_ARADDR  = '0;
  assign M_AXI_ARLEN   = '0;
  assign M_AXI_ARSIZE  = '0;
  assign M_AXI_ARBURST = '0;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARCACHE = '0;
  assign M_AXI_ARQOS   = '0;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;

  assign unused_ok = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID};

endmodule

// File: tb/tb_ram_writer.sv
// Bench for ram_writer: directed frame table, hand sequences for abort/ignored start,
// and randomized frames checked against a beat-level model of the RAM write stream.
module tb_ram_writer;

  localparam int          DW   = 32;
  localparam int          CPB  = 4;
  localparam logic [63:0] BASE = 64'h0000_1234_0000_0000;
  localparam logic [31:0] MAXB = 32'd2;
  localparam int          CAP  = 8;
  localparam logic [63:0] BLKB = 64'd16;

  logic clk = 1'b0;
  logic resetn, start, idle, overflow, bresp_error;
  logic [31:0] full_blocks;
  logic [7:0]  partial_block_cycles;
  logic [DW-1:0] TDATA;
  logic TVALID, TLAST, TREADY;
  logic [63:0] AWADDR; logic [7:0] AWLEN; logic [2:0] AWSIZE; logic [1:0] AWBURST;
  logic [3:0] AWID, AWCACHE, AWQOS; logic AWLOCK; logic [2:0] AWPROT; logic AWVALID, AWREADY;
  logic [DW-1:0] WDATA; logic [DW/8-1:0] WSTRB; logic WVALID, WLAST, WREADY;
  logic [1:0] BRESP; logic BVALID, BREADY;
  logic [63:0] ARADDR; logic [7:0] ARLEN; logic [2:0] ARSIZE; logic [1:0] ARBURST;
  logic [3:0] ARID, ARCACHE, ARQOS; logic ARLOCK; logic [2:0] ARPROT; logic ARVALID;
  logic [DW-1:0] RDATA; logic [1:0] RRESP; logic RLAST, RVALID, RREADY;

  always #5 clk = ~clk;

  ram_writer #(.DW(DW), .CYCLES_PER_BLOCK(CPB), .RAM_BASE_ADDR(BASE), .MAX_BLOCKS(MAXB)) dut (
    .clk(clk), .resetn(resetn), .start(start), .idle(idle),
    .full_blocks(full_blocks), .partial_block_cycles(partial_block_cycles),
    .overflow(overflow), .bresp_error(bresp_error),
    .AXIS_IN_TDATA(TDATA), .AXIS_IN_TVALID(TVALID), .AXIS_IN_TLAST(TLAST), .AXIS_IN_TREADY(TREADY),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE), .M_AXI_AWBURST(AWBURST),
    .M_AXI_AWID(AWID), .M_AXI_AWCACHE(AWCACHE), .M_AXI_AWQOS(AWQOS), .M_AXI_AWLOCK(AWLOCK),
    .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WLAST(WLAST),
    .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE), .M_AXI_ARBURST(ARBURST),
    .M_AXI_ARID(ARID), .M_AXI_ARCACHE(ARCACHE), .M_AXI_ARQOS(ARQOS), .M_AXI_ARLOCK(ARLOCK),
    .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(1'b0),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST), .M_AXI_RVALID(RVALID),
    .M_AXI_RREADY(RREADY)
  );

  int nchk = 0, nfail = 0, cyc = 0;
  int aw_n, wlast_n, b_issued, err_burst, stall_mode, b_fix;
  bit start_req;
  logic [63:0] aw_log[$];
  logic [31:0] wd_log[$];
  logic [3:0]  ws_log[$];
  logic        wl_log[$];
  int          b_due[$];
  logic [31:0] src_q[$], frame[$];

  typedef struct {
    int len; int err; int stall; int bfix;
    int full; int part; int ovf; int berr; int naw;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then drive the next inputs after the rising edge
  task automatic tick();
    bit axis_hs;
    axis_hs = 1'b0;
    @(negedge clk);
    cyc++;
    if (start) chk("idle_low_on_start", idle, 0);
    if (resetn) begin
      if (AWVALID && AWREADY) begin
        aw_log.push_back(AWADDR);
        aw_n++;
        chk("awlen", AWLEN, CPB - 1);
        chk("awsize", AWSIZE, 2);
        chk("awburst", AWBURST, 1);
        chk("aw_at_most_one_ahead", (aw_n - wlast_n) <= 1, 1);
      end
      if (WVALID && WREADY) begin
        chk("w_after_aw", aw_n > wlast_n, 1);
        wd_log.push_back(WDATA);
        ws_log.push_back(WSTRB);
        wl_log.push_back(WLAST);
        if (WLAST) begin
          wlast_n++;
          b_due.push_back(cyc + ((b_fix > 0) ? b_fix : $urandom_range(1, 6)));
        end
      end
      axis_hs = TVALID && TREADY;
    end
    @(posedge clk);
    #1;
    start = start_req;
    start_req = 1'b0;
    if (axis_hs) begin TVALID = 1'b0; TLAST = 1'b0; end
    if (!TVALID && src_q.size() > 0 && (stall_mode == 0 || $urandom_range(0, 2) != 0)) begin
      TDATA  = src_q.pop_front();
      TLAST  = (src_q.size() == 0);
      TVALID = 1'b1;
    end
    WREADY  = (stall_mode == 0) || ($urandom_range(0, 3) != 0);
    AWREADY = (stall_mode == 0) || ($urandom_range(0, 2) == 0);
    BVALID = 1'b0;
    BRESP  = 2'b00;
    if (b_due.size() > 0 && b_due[0] <= cyc) begin
      BVALID = 1'b1;
      BRESP  = (b_issued == err_burst) ? 2'b10 : 2'b00;
      b_due.delete(0);
      b_issued++;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    src_q.delete(); b_due.delete();
    TVALID = 1'b0; TLAST = 1'b0; BVALID = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic begin_frame(input int len, input int err, input int stall, input int bfix);
    aw_log.delete(); wd_log.delete(); ws_log.delete(); wl_log.delete(); frame.delete();
    aw_n = 0; wlast_n = 0; b_issued = 0;
    err_burst = err; stall_mode = stall; b_fix = bfix;
    for (int i = 0; i < len; i++) frame.push_back($urandom);
    start_req = 1'b1;
    tick();
    src_q = frame;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      tick();
      if (idle) ok = 1'b1;
    end
    chk("frame_completes", ok, 1);
    if (ok) begin
      chk("all_b_before_idle", b_issued, aw_n);
      chk("no_b_pending", b_due.size(), 0);
      repeat (3) tick();
      chk("idle_holds", idle, 1);
    end else begin
      do_reset();
    end
  endtask

  task automatic check_frame(input int len, input int efull, input int epart, input int eovf,
                             input int eberr, input int enaw);
    int kept, nblk;
    kept = (len > CAP) ? CAP : len;
    nblk = (kept + CPB - 1) / CPB;
    chk("full_blocks", full_blocks, efull);
    chk("partial_block_cycles", partial_block_cycles, epart);
    chk("overflow", overflow, eovf);
    chk("bresp_error", bresp_error, eberr);
    chk("aw_count", aw_log.size(), enaw);
    for (int i = 0; i < aw_log.size() && i < enaw; i++)
      chk("awaddr", aw_log[i], BASE + 64'(i) * BLKB);
    chk("w_beats", wd_log.size(), nblk * CPB);
    for (int i = 0; i < wd_log.size() && i < nblk * CPB; i++) begin
      chk("wdata", wd_log[i], (i < kept) ? frame[i] : 32'd0);
      chk("wstrb", ws_log[i], (i < kept) ? 4'hF : 4'h0);
      chk("wlast", wl_log[i], (i % CPB) == CPB - 1);
    end
    chk("stream_drained", src_q.size() + int'(TVALID), 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int len, err, stall, kept;
    resetn = 1'b0; start = 1'b0; start_req = 1'b0;
    TDATA = '0; TVALID = 1'b0; TLAST = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
    BRESP = 2'b00; BVALID = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
    aw_n = 0; wlast_n = 0; b_issued = 0; err_burst = -1; stall_mode = 0; b_fix = 1;
    repeat (3) tick();
    chk("rst_idle", idle, 1);
    chk("rst_full_blocks", full_blocks, 0);
    chk("rst_partial", partial_block_cycles, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_bresp_error", bresp_error, 0);
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_tready", TREADY, 0);
    chk("arvalid_tied", ARVALID, 0);
    chk("rready_tied", RREADY, 0);
    chk("bready_high", BREADY, 1);
    resetn = 1'b1;
    tick();

    //           len err st bfix full part ovf berr naw
    tbl[0] = '{ 8, -1, 0, 1,  2,   0,   0,  0,   2};
    tbl[1] = '{ 6, -1, 0, 1,  1,   2,   0,  0,   2};
    tbl[2] = '{ 1, -1, 0, 1,  0,   1,   0,  0,   1};
    tbl[3] = '{11, -1, 0, 1,  2,   0,   1,  0,   2};
    tbl[4] = '{ 5,  0, 0, 1,  1,   1,   0,  1,   2};
    tbl[5] = '{ 4, -1, 1, 4,  1,   0,   0,  0,   1};
    tbl[6] = '{ 7, -1, 1, 4,  1,   3,   0,  0,   2};
    tbl[7] = '{12,  1, 1, 4,  2,   0,   1,  1,   2};
    for (int t = 0; t < 8; t++) begin
      begin_frame(tbl[t].len, tbl[t].err, tbl[t].stall, tbl[t].bfix);
      wait_frame(ok);
      if (ok) check_frame(tbl[t].len, tbl[t].full, tbl[t].part, tbl[t].ovf, tbl[t].berr, tbl[t].naw);
    end

    // start pulsed mid-frame after an error response must not clear anything
    begin_frame(6, 0, 0, 1);
    for (int i = 0; i < 200 && b_issued < 1; i++) tick();
    chk("first_b_seen", b_issued >= 1, 1);
    start_req = 1'b1;
    wait_frame(ok);
    if (ok) check_frame(6, 1, 2, 0, 1, 2);

    // Overflowing, erroring frame, then asynchronous reset in the middle of the next burst
    begin_frame(12, 0, 0, 1);
    wait_frame(ok);
    chk("pre_abort_overflow", overflow, 1);
    begin_frame(8, -1, 0, 1);
    for (int i = 0; i < 200 && wd_log.size() < 2; i++) tick();
    chk("abort_reached_data", wd_log.size() >= 2, 1);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("abort_idle", idle, 1);
    chk("abort_awvalid", AWVALID, 0);
    chk("abort_wvalid", WVALID, 0);
    chk("abort_tready", TREADY, 0);
    chk("abort_full_blocks", full_blocks, 0);
    chk("abort_overflow", overflow, 0);
    chk("abort_bresp_error", bresp_error, 0);
    src_q.delete(); b_due.delete();
    TVALID = 1'b0; TLAST = 1'b0; BVALID = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    tick();

    for (int r = 0; r < 25; r++) begin
      len   = $urandom_range(1, 12);
      err   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : -1;
      stall = $urandom_range(0, 1);
      begin_frame(len, err, stall, stall ? 4 : 0);
      wait_frame(ok);
      kept = (len > CAP) ? CAP : len;
      if (ok)
        check_frame(len, kept / CPB, (len > CAP) ? 0 : kept % CPB, int'(len > CAP),
                    int'(err >= 0 && err < (kept + CPB - 1) / CPB), (kept + CPB - 1) / CPB);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
